axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 burst master: accepts one command at a time, runs a single INCR write or read
// burst on the AXI4 master channels and reports completion with a one-cycle done pulse.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [2:0]              dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_ERR
  } state_t;

  // Every handshake pair here uses strict AXI semantics: a transfer happens on the
  // rising edge where valid and ready are both 1; valid never depends on ready.

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rresp_set_q, rresp_set_d;
  logic                  len_err_q, len_err_d;

  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [31:0]           burst_end;
  logic                  crosses_4k;
  logic                  beat_len_err;
  logic [1:0]            sticky_resp;
  logic                  unused_ids;

  assign aligned_addr = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign burst_end    = 32'(aligned_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
  assign crosses_4k   = burst_end > 32'd4096;
  assign unused_ids   = ^{m_axi_bid, m_axi_rid};

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign rd_data       = m_axi_rdata;
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rresp_q     <= '0;
      rresp_set_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rresp_q     <= rresp_d;
      rresp_set_q <= rresp_set_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    id_d          = id_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    rresp_d       = rresp_q;
    rresp_set_d   = rresp_set_q;
    len_err_d     = len_err_q;
    // cmd_ready is gated by rst_n so it reads 0 while reset is held.
    cmd_ready     = (state_q == ST_IDLE) && rst_n;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done_valid    = 1'b0;
    done_resp     = 2'b00;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    beat_len_err  = 1'b0;
    sticky_resp   = rresp_set_q ? rresp_q : m_axi_rresp;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = aligned_addr;
          id_d        = cmd_id;
          len_d       = cmd_len;
          cnt_d       = '0;
          rresp_d     = 2'b00;
          rresp_set_d = 1'b0;
          len_err_d   = 1'b0;
          if (crosses_4k)     state_d = ST_ERR;
          else if (cmd_write) state_d = ST_AW;
          else                state_d = ST_AR;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == len_q);
        if (wr_valid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_B;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          done_valid = 1'b1;
          done_resp  = m_axi_bresp;
          state_d    = ST_IDLE;
        end
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        rd_last      = m_axi_rlast;
        if (m_axi_rvalid && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          // A beat is malformed when rlast disagrees with the expected final beat.
          beat_len_err = m_axi_rlast != (cnt_q == len_q);
          if (beat_len_err) len_err_d = 1'b1;
          if (!rresp_set_q && (m_axi_rresp != 2'b00)) begin
            rresp_d     = m_axi_rresp;
            rresp_set_d = 1'b1;
          end
          if (m_axi_rlast) begin
            done_valid = 1'b1;
            done_resp  = (len_err_q || beat_len_err) ? 2'b10 : sticky_resp;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        done_valid = 1'b1;
        done_resp  = 2'b10;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a bench-side AXI slave with word memory, a command and
// stream driver, and a scoreboard fed by a transaction-level model of the burst rules.
`timescale 1ns/1ps
module tb_axi_burst_master;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int IW    = 8;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 1 << (AW - $clog2(BYTES));
  localparam logic [2:0] EXP_SIZE = 3'($clog2(BYTES));

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
  logic          done_valid;
  logic [1:0]    done_resp;
  logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [BYTES-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [2:0]    unused_dbg_state;

  axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(unused_dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [AW+8+IW:0] exp_ax_q[$];   // {is_read, addr, len, id}
  logic [DW:0]      exp_w_q[$];    // {wlast, wdata}
  logic [DW:0]      exp_rd_q[$];   // {rd_last, rd_data}
  logic [1:0]       exp_done_q[$];
  bit               quiet_axi = 1'b0;

  // slave memory and per-transaction slave configuration
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata_cfg [256];
  logic [1:0]    rresp_cfg [256];
  logic [1:0]    bresp_cfg;
  int            rlast_beat;
  int            aw_delay;
  bit            rd_toggle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  function automatic int widx(input logic [AW-1:0] a, input int beat);
    return ((int'(a) / BYTES) + beat) % DEPTH;
  endfunction

  // Transaction-level model: what the master must do for one command.
  task automatic model_txn(input bit write, input logic [AW-1:0] addr, input int len,
                           input logic [IW-1:0] id, output bit crosses);
    logic [AW-1:0] base;
    logic [1:0]    resp;
    base    = addr & ~AW'(BYTES - 1);
    crosses = (int'(base[11:0]) + (len + 1) * BYTES) > 4096;
    if (crosses) begin
      exp_done_q.push_back(2'b10);
    end else if (write) begin
      exp_ax_q.push_back({1'b0, base, 8'(len), id});
      for (int i = 0; i <= len; i++) exp_w_q.push_back({i == len, wdata_cfg[i]});
      exp_done_q.push_back(bresp_cfg);
    end else begin
      exp_ax_q.push_back({1'b1, base, 8'(len), id});
      for (int i = 0; i <= rlast_beat; i++)
        exp_rd_q.push_back({i == rlast_beat, mem[widx(base, i)]});
      resp = 2'b00;
      for (int i = len; i >= 0; i--) if (rresp_cfg[i] != 2'b00) resp = rresp_cfg[i];
      if (rlast_beat != len) resp = 2'b10;
      exp_done_q.push_back(resp);
    end
  endtask

  // compare process: one pass per cycle, away from the rising edge
  logic             aw_hold, ar_hold;
  logic [AW+8+IW:0] ax_e;
  logic [DW:0]      d_e;
  logic [1:0]       r_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      if (aw_hold) check("awvalid_stable", 64'(m_axi_awvalid), 64'd1);
      if (ar_hold) check("arvalid_stable", 64'(m_axi_arvalid), 64'd1);
      aw_hold <= m_axi_awvalid && !m_axi_awready;
      ar_hold <= m_axi_arvalid && !m_axi_arready;
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_ax_q.size() == 0) fail_evt("aw_unexpected", 64'(m_axi_awaddr));
        else begin
          ax_e = exp_ax_q.pop_front();
          check("aw_fields", 64'({1'b0, m_axi_awaddr, m_axi_awlen, m_axi_awid}), 64'(ax_e));
        end
        check("aw_attr", 64'({m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot}),
              64'({EXP_SIZE, 2'b01, 1'b0, 4'b0011, 3'b000}));
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ax_q.size() == 0) fail_evt("ar_unexpected", 64'(m_axi_araddr));
        else begin
          ax_e = exp_ax_q.pop_front();
          check("ar_fields", 64'({1'b1, m_axi_araddr, m_axi_arlen, m_axi_arid}), 64'(ax_e));
        end
        check("ar_attr", 64'({m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}),
              64'({EXP_SIZE, 2'b01, 1'b0, 4'b0011, 3'b000}));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w_q.size() == 0) fail_evt("w_unexpected", 64'(m_axi_wdata));
        else begin
          d_e = exp_w_q.pop_front();
          check("w_beat", 64'({m_axi_wlast, m_axi_wdata}), 64'(d_e));
        end
        check("w_strb", 64'(m_axi_wstrb), 64'({BYTES{1'b1}}));
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) fail_evt("rd_unexpected", 64'(rd_data));
        else begin
          d_e = exp_rd_q.pop_front();
          check("rd_beat", 64'({rd_last, rd_data}), 64'(d_e));
        end
      end
      if (done_valid) begin
        if (exp_done_q.size() == 0) fail_evt("done_unexpected", 64'(done_resp));
        else begin
          r_e = exp_done_q.pop_front();
          check("done_resp", 64'(done_resp), 64'(r_e));
        end
        check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
      end
      if (quiet_axi) check("no_axi_activity", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid}), 64'd0);
    end
  end

  task automatic clear_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
  endtask

  task automatic cfg_default(input int len);
    bresp_cfg  = 2'b00;
    rlast_beat = len;
    aw_delay   = 0;
    rd_toggle  = 0;
    for (int i = 0; i < 256; i++) begin
      rresp_cfg[i] = 2'b00;
      wdata_cfg[i] = $urandom;
    end
  endtask

  // driver + AXI slave: drives at posedge+1, observes handshakes at negedge
  task automatic run_txn(input bit write, input logic [AW-1:0] addr, input int len,
                         input logic [IW-1:0] id, input int abort_after);
    bit acc, done, ar_done, w_hs, r_hs;
    int aw_cnt, w_acc, r_sent, nr;
    logic [AW-1:0] aw_cap, ar_cap;
    acc = 0; done = 0; ar_done = 0; w_hs = 0; r_hs = 0;
    aw_cnt = 0; w_acc = 0; r_sent = 0; nr = rlast_beat + 1;
    aw_cap = '0; ar_cap = '0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = write; cmd_addr = addr; cmd_len = 8'(len); cmd_id = id;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!acc) begin
      fail_evt("cmd_accept_timeout", 64'(cmd_ready));
      return;
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
      if (m_axi_awvalid) aw_cnt++;
      m_axi_arready = m_axi_arvalid && (aw_cnt >= aw_delay);
      if (m_axi_arvalid) aw_cnt++;
      if (write && w_acc <= len) begin
        if (w_hs || !wr_valid) wr_valid = ($urandom_range(0, 3) != 0);
        wr_data = wdata_cfg[w_acc];
      end else wr_valid = 0;
      m_axi_wready = 1'($urandom_range(0, 1));
      m_axi_bvalid = write && (w_acc == len + 1);
      m_axi_bresp  = bresp_cfg;
      if (ar_done && r_sent < nr) begin
        if (r_hs || !m_axi_rvalid) m_axi_rvalid = ($urandom_range(0, 3) != 0);
        m_axi_rdata = mem[widx(ar_cap, r_sent)];
        m_axi_rresp = rresp_cfg[r_sent];
        m_axi_rlast = (r_sent == rlast_beat);
      end else begin
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
      end
      rd_ready = rd_toggle ? ~rd_ready : 1'($urandom_range(0, 1));
      if (abort_after >= 0 && w_acc == abort_after) begin
        wr_valid = 1;
        #1 check("wvalid_before_reset", 64'(m_axi_wvalid), 64'd1);
        #1 rst_n = 0;
        #1;
        check("reset_kills_w", 64'({m_axi_wvalid, wr_ready, m_axi_wlast, done_valid, cmd_ready}), 64'd0);
        exp_ax_q.delete(); exp_w_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        clear_inputs();
        return;
      end
      @(negedge clk);
      w_hs = m_axi_wvalid && m_axi_wready;
      r_hs = m_axi_rvalid && m_axi_rready;
      if (m_axi_awvalid && m_axi_awready) aw_cap = m_axi_awaddr;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_cap  = m_axi_araddr;
        ar_done = 1;
      end
      if (w_hs) begin
        mem[widx(aw_cap, w_acc)] = m_axi_wdata;
        w_acc++;
      end
      if (r_hs) r_sent++;
      done = done_valid;
      @(posedge clk); #1;
    end
    clear_inputs();
    if (!done) fail_evt("txn_timeout", 64'(addr));
    else check("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    check("queues_drained", 64'(exp_ax_q.size() + exp_w_q.size() + exp_rd_q.size() + exp_done_q.size()), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cr;
    bit wr;
    int ln;
    logic [AW-1:0] a;
    rst_n = 0;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    // reset: drive active inputs to prove every output is gated off
    wr_valid = 1; m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_bvalid = 1;
    m_axi_awready = 1; m_axi_arready = 1; m_axi_wready = 1; rd_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_handshakes", 64'({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_wlast,
          m_axi_bready, m_axi_rready, rd_valid, rd_last, wr_ready}), 64'd0);
    check("reset_done", 64'({done_valid, done_resp}), 64'd0);
    check("reset_regs", 64'({m_axi_awaddr, m_axi_awid, m_axi_awlen}), 64'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // write 0x0100 len 3, awready delayed by 2 cycles
    cfg_default(3);
    aw_delay = 2;
    for (int i = 0; i < 4; i++) wdata_cfg[i] = 32'hA0 + i;
    exp_ax_q.push_back({1'b0, 16'h0100, 8'd3, 8'h11});
    for (int i = 0; i < 4; i++) exp_w_q.push_back({i == 3, 32'hA0 + 32'(i)});
    exp_done_q.push_back(2'b00);
    run_txn(1'b1, 16'h0100, 3, 8'h11, -1);

    // read back with rd_ready toggling every cycle
    cfg_default(3);
    rd_toggle = 1;
    exp_ax_q.push_back({1'b1, 16'h0100, 8'd3, 8'h22});
    for (int i = 0; i < 4; i++) exp_rd_q.push_back({i == 3, 32'hA0 + 32'(i)});
    exp_done_q.push_back(2'b00);
    run_txn(1'b0, 16'h0100, 3, 8'h22, -1);

    // 4 KB crossing: no AXI traffic, SLVERR
    cfg_default(3);
    exp_done_q.push_back(2'b10);
    quiet_axi = 1;
    run_txn(1'b1, 16'h0FF8, 3, 8'h33, -1);
    quiet_axi = 0;

    // SLVERR on beat 1 is sticky across the remaining beats
    cfg_default(3);
    rresp_cfg[1] = 2'b10;
    exp_ax_q.push_back({1'b1, 16'h0100, 8'd3, 8'h44});
    for (int i = 0; i < 4; i++) exp_rd_q.push_back({i == 3, 32'hA0 + 32'(i)});
    exp_done_q.push_back(2'b10);
    run_txn(1'b0, 16'h0100, 3, 8'h44, -1);

    // early rlast on the third beat of a len=3 read
    cfg_default(3);
    rlast_beat = 2;
    exp_ax_q.push_back({1'b1, 16'h0100, 8'd3, 8'h55});
    for (int i = 0; i < 3; i++) exp_rd_q.push_back({i == 2, 32'hA0 + 32'(i)});
    exp_done_q.push_back(2'b10);
    run_txn(1'b0, 16'h0100, 3, 8'h55, -1);

    // reset while the second write beat is pending, then a single-beat write
    cfg_default(3);
    model_txn(1'b1, 16'h0200, 3, 8'h66, cr);
    run_txn(1'b1, 16'h0200, 3, 8'h66, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("cmd_ready_after_midburst_reset", 64'(cmd_ready), 64'd1);
    cfg_default(0);
    wdata_cfg[0] = 32'hC5;
    exp_ax_q.push_back({1'b0, 16'h0300, 8'd0, 8'h77});
    exp_w_q.push_back({1'b1, 32'hC5});
    exp_done_q.push_back(2'b00);
    run_txn(1'b1, 16'h0300, 0, 8'h77, -1);

    // randomized commands checked against the model
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      ln = $urandom_range(0, 15);
      a  = AW'($urandom_range(0, 15) << 12);
      if ($urandom_range(0, 3) == 0) a = a | AW'(4096 - $urandom_range(1, 64));
      else                           a = a | AW'($urandom_range(0, 4095));
      cfg_default(ln);
      bresp_cfg = 2'($urandom_range(0, 3));
      aw_delay  = $urandom_range(0, 3);
      for (int i = 0; i < 256; i++) if ($urandom_range(0, 9) == 0) rresp_cfg[i] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 6) == 0 && ln > 0) rlast_beat = $urandom_range(0, ln - 1);
      else if ($urandom_range(0, 9) == 0) rlast_beat = ln + $urandom_range(1, 2);
      model_txn(wr, a, ln, 8'(t), cr);
      quiet_axi = cr;
      run_txn(wr, a, ln, 8'(t), -1);
      quiet_axi = 0;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
